// File: rtl/bridge_sample_fetcher.sv
// Fetches a run of 16-bit words over a single-outstanding read bridge and
// buffers them in a small FIFO for a valid/ready downstream consumer.
module bridge_sample_fetcher #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    input  logic [25:0] base_addr,
    input  logic [23:0] word_count,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [25:0] bus_address,
    output logic [1:0]  bus_byte_enable,
    output logic        bus_read,
    output logic        bus_write,
    output logic [15:0] bus_write_data,
    input  logic        bus_acknowledge,
    input  logic [15:0] bus_read_data,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state;
    logic [23:0]   remaining;
    logic [TW-1:0] tcnt;
    logic          abort_pend;

    logic          rst_meta_p0;
    logic          rst_sync_p1;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fcount;

    logic          start_ok;
    logic          stop_req;
    logic          ack_hit;
    logic          tmo_hit;
    logic          push;
    logic          pop;
    logic          flush;
    logic          fifo_room;
    logic          unused_base_lsb;

    // Reset release passes through two flops before a start may be accepted;
    // assertion still clears every state flop asynchronously.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rst_meta_p0 <= 1'b0;
            rst_sync_p1 <= 1'b0;
        end else begin
            rst_meta_p0 <= 1'b1;
            rst_sync_p1 <= rst_meta_p0;
        end
    end

    assign unused_base_lsb = base_addr[0];
    assign bus_write       = 1'b0;
    assign bus_write_data  = 16'h0000;

    assign start_ok  = (state == IDLE) && start && !abort && rst_sync_p1;
    assign stop_req  = abort || abort_pend;
    assign ack_hit   = (state == REQ) && bus_acknowledge;
    assign tmo_hit   = (state == REQ) && !bus_acknowledge && (tcnt == TMO_LAST);
    assign push      = ack_hit && !stop_req;
    assign pop       = sample_valid && sample_ready;
    assign fifo_room = (fcount < FULL_LVL);
    assign flush     = (ack_hit && stop_req) || tmo_hit ||
                       (((state == GAP) || (state == DRAIN)) && abort);

    assign sample_valid = (fcount != '0);
    assign sample_data  = sample_valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
            bus_read        <= 1'b0;
            bus_byte_enable <= 2'b00;
            bus_address     <= '0;
            remaining       <= '0;
            tcnt            <= '0;
            abort_pend      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        bus_address <= {base_addr[25:1], 1'b0};
                        remaining   <= word_count;
                        timeout_err <= 1'b0;
                        abort_pend  <= 1'b0;
                        busy        <= 1'b1;
                        if (word_count == '0) begin
                            state <= DRAIN;
                        end else begin
                            state           <= REQ;
                            bus_read        <= 1'b1;
                            bus_byte_enable <= 2'b11;
                            tcnt            <= '0;
                        end
                    end
                end
                REQ: begin
                    // An abort here cannot cancel the bridge cycle; it is
                    // remembered and the returning word is dropped.
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (bus_acknowledge) begin
                        bus_read        <= 1'b0;
                        bus_byte_enable <= 2'b00;
                        if (stop_req) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            abort_pend <= 1'b0;
                        end else begin
                            bus_address <= bus_address + 26'd2;
                            remaining   <= remaining - 1'b1;
                            state       <= GAP;
                        end
                    end else if (tcnt == TMO_LAST) begin
                        bus_read        <= 1'b0;
                        bus_byte_enable <= 2'b00;
                        timeout_err     <= 1'b1;
                        state           <= IDLE;
                        busy            <= 1'b0;
                        abort_pend      <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (remaining == '0) begin
                        state <= DRAIN;
                    end else if (fifo_room) begin
                        state           <= REQ;
                        bus_read        <= 1'b1;
                        bus_byte_enable <= 2'b11;
                        tcnt            <= '0;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fcount == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sample FIFO: pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fcount <= fcount + 1'b1;
                2'b01:   fcount <= fcount - 1'b1;
                default: fcount <= fcount;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus_read_data;
        end
    end

endmodule

// File: tb/tb_bridge_sample_fetcher.sv
// Scoreboard bench for bridge_sample_fetcher: a bridge responder returns an
// address-derived word, and delivered samples are matched against a queue.
module tb_bridge_sample_fetcher;

    logic        clk = 1'b0;
    logic        reset_reset_n = 1'b1;
    logic        start = 1'b0;
    logic [25:0] base_addr = '0;
    logic [23:0] word_count = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [25:0] bus_address;
    logic [1:0]  bus_byte_enable;
    logic        bus_read;
    logic        bus_write;
    logic [15:0] bus_write_data;
    logic        bus_acknowledge = 1'b0;
    logic [15:0] bus_read_data = '0;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acks   = 0;
    int n_done   = 0;
    int n_samples = 0;
    int n_rises  = 0;
    int gap_viol = 0;
    int hold_viol = 0;
    int be_viol  = 0;
    int wr_viol  = 0;
    int ack_delay = 0;
    bit ack_en   = 1'b1;

    logic        m_prev_acc  = 1'b0;
    logic        m_prev_read = 1'b0;
    logic [25:0] m_prev_addr = '0;

    logic [25:0] addr_q[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    bridge_sample_fetcher #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk_clk         (clk),
        .reset_reset_n   (reset_reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .word_count      (word_count),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .timeout_err     (timeout_err),
        .bus_address     (bus_address),
        .bus_byte_enable (bus_byte_enable),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_write_data  (bus_write_data),
        .bus_acknowledge (bus_acknowledge),
        .bus_read_data   (bus_read_data),
        .sample_data     (sample_data),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready)
    );

    function automatic logic [15:0] pat(input logic [25:0] a);
        return a[16:1] ^ 16'h5A3C;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [25:0] base, input logic [23:0] cnt, input bit model);
        logic [25:0] a;
        @(posedge clk);
        #1;
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        if (model) begin
            for (int i = 0; i < int'(cnt); i++) begin
                a = {base[25:1], 1'b0} + 26'(2 * i);
                addr_q.push_back(a);
                exp_q.push_back(pat(a));
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int d0;
        int i;
        d0 = n_done;
        i  = 0;
        while (n_done == d0 && i < bound) begin
            tick(1);
            i++;
        end
        check_eq(tag, 32'(n_done != d0), 32'd1);
    endtask

    task automatic clear_q();
        addr_q.delete();
        exp_q.delete();
    endtask

    // Bridge responder: acknowledges after ack_delay waiting cycles.
    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            bus_acknowledge = 1'b0;
            if (bus_read && ack_en) begin
                if (wait_cnt >= ack_delay) begin
                    bus_acknowledge = 1'b1;
                    bus_read_data   = pat(bus_address);
                    n_acks++;
                    wait_cnt = 0;
                    if (addr_q.size() == 0) begin
                        check_eq("rd_extra", 32'd1, 32'd0);
                    end else begin
                        check_eq("rd_addr", 32'(bus_address), 32'(addr_q.pop_front()));
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (bus_read && !m_prev_read) n_rises++;
            if (m_prev_acc && bus_read) gap_viol++;
            if (bus_read && m_prev_read && !m_prev_acc && bus_address != m_prev_addr) hold_viol++;
            if (bus_read && bus_byte_enable != 2'b11) be_viol++;
            if (bus_write || bus_write_data != 16'h0) wr_viol++;
            if (sample_valid && sample_ready) begin
                n_samples++;
                if (exp_q.size() == 0) begin
                    check_eq("sample_extra", 32'd1, 32'd0);
                end else begin
                    check_eq("sample", 32'(sample_data), 32'(exp_q.pop_front()));
                end
            end
            m_prev_acc  = bus_read && bus_acknowledge;
            m_prev_read = bus_read;
            m_prev_addr = bus_address;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : main
        int d0, a0, s0, r0, hi;

        #2 reset_reset_n = 1'b0;
        tick(2);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(timeout_err), 32'd0);
        check_eq("rst_read", 32'(bus_read), 32'd0);
        check_eq("rst_addr", 32'(bus_address), 32'd0);
        check_eq("rst_be", 32'(bus_byte_enable), 32'd0);
        check_eq("rst_valid", 32'(sample_valid), 32'd0);
        check_eq("rst_data", 32'(sample_data), 32'd0);
        @(posedge clk);
        #1 reset_reset_n = 1'b1;
        tick(4);

        // Basic four-word fetch with slow acknowledges
        sample_ready = 1'b1;
        ack_delay = 3;
        d0 = n_done;
        do_start(26'h0000100, 24'd4, 1'b1);
        tick(1);
        check_eq("t1_busy", 32'(busy), 32'd1);
        wait_done(200, "t1_done");
        tick(5);
        check_eq("t1_done_cnt", 32'(n_done - d0), 32'd1);
        check_eq("t1_busy_after", 32'(busy), 32'd0);
        check_eq("t1_samples_left", 32'(exp_q.size()), 32'd0);
        check_eq("t1_reads_left", 32'(addr_q.size()), 32'd0);

        // FIFO backpressure: only FIFO_DEPTH reads while downstream stalls
        sample_ready = 1'b0;
        ack_delay = 1;
        a0 = n_acks;
        d0 = n_done;
        do_start(26'h0002000, 24'd20, 1'b1);
        tick(200);
        check_eq("t2_reads_stalled", 32'(n_acks - a0), 32'd8);
        check_eq("t2_read_low", 32'(bus_read), 32'd0);
        check_eq("t2_valid", 32'(sample_valid), 32'd1);
        check_eq("t2_head", 32'(sample_data), 32'(pat(26'h0002000)));
        @(posedge clk);
        #1 sample_ready = 1'b1;
        wait_done(1000, "t2_done");
        tick(3);
        check_eq("t2_reads_total", 32'(n_acks - a0), 32'd20);
        check_eq("t2_samples_left", 32'(exp_q.size()), 32'd0);
        check_eq("t2_done_cnt", 32'(n_done - d0), 32'd1);

        // Address wrap, with a second start issued while busy
        ack_delay = 2;
        d0 = n_done;
        do_start(26'h3FFFFFE, 24'd2, 1'b1);
        do_start(26'h0007000, 24'd5, 1'b0);
        wait_done(200, "t3_done");
        tick(3);
        check_eq("t3_reads_left", 32'(addr_q.size()), 32'd0);
        check_eq("t3_samples_left", 32'(exp_q.size()), 32'd0);
        check_eq("t3_done_cnt", 32'(n_done - d0), 32'd1);

        // Odd base address is fetched from the even word below it
        do_start(26'h0000201, 24'd1, 1'b1);
        wait_done(100, "t3b_done");
        tick(2);
        check_eq("t3b_samples_left", 32'(exp_q.size()), 32'd0);

        // Bridge never answers: timeout
        ack_en = 1'b0;
        d0 = n_done;
        do_start(26'h0000040, 24'd3, 1'b1);
        hi = 0;
        tick(1);
        while (bus_read && hi < 3000) begin
            hi++;
            tick(1);
        end
        check_eq("t4_read_cycles", 32'(hi), 32'd1024);
        check_eq("t4_err", 32'(timeout_err), 32'd1);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_valid", 32'(sample_valid), 32'd0);
        tick(3);
        check_eq("t4_no_done", 32'(n_done - d0), 32'd0);
        check_eq("t4_err_sticky", 32'(timeout_err), 32'd1);
        clear_q();
        ack_en = 1'b1;
        do_start(26'h0000040, 24'd1, 1'b1);
        tick(1);
        check_eq("t4_err_cleared", 32'(timeout_err), 32'd0);
        wait_done(100, "t4_done");
        tick(2);

        // Abort while a read is outstanding
        ack_delay = 5;
        sample_ready = 1'b1;
        d0 = n_done;
        a0 = n_acks;
        s0 = n_samples;
        do_start(26'h0000500, 24'd4, 1'b1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        tick(1);
        check_eq("t5_read_held", 32'(bus_read), 32'd1);
        hi = 0;
        while (bus_read && hi < 50) begin
            hi++;
            tick(1);
        end
        tick(4);
        check_eq("t5_acks", 32'(n_acks - a0), 32'd1);
        check_eq("t5_read_low", 32'(bus_read), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_valid", 32'(sample_valid), 32'd0);
        check_eq("t5_no_samples", 32'(n_samples - s0), 32'd0);
        check_eq("t5_no_done", 32'(n_done - d0), 32'd0);
        clear_q();

        // Abort while parked in GAP with a full FIFO
        sample_ready = 1'b0;
        ack_delay = 0;
        d0 = n_done;
        do_start(26'h0000600, 24'd20, 1'b1);
        tick(60);
        check_eq("t6_full", 32'(sample_valid), 32'd1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        tick(1);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_flushed", 32'(sample_valid), 32'd0);
        check_eq("t6_no_done", 32'(n_done - d0), 32'd0);
        clear_q();
        sample_ready = 1'b1;

        // Start together with abort in IDLE is ignored
        r0 = n_rises;
        @(posedge clk);
        #1;
        base_addr  = 26'h0000700;
        word_count = 24'd2;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        tick(3);
        check_eq("t7_busy", 32'(busy), 32'd0);
        check_eq("t7_no_read", 32'(n_rises - r0), 32'd0);

        // Reset in the middle of a read
        ack_delay = 10;
        do_start(26'h0000800, 24'd4, 1'b1);
        tick(2);
        reset_reset_n = 1'b0;
        #1;
        check_eq("t8_read", 32'(bus_read), 32'd0);
        check_eq("t8_busy", 32'(busy), 32'd0);
        check_eq("t8_addr", 32'(bus_address), 32'd0);
        check_eq("t8_be", 32'(bus_byte_enable), 32'd0);
        check_eq("t8_valid", 32'(sample_valid), 32'd0);
        check_eq("t8_data", 32'(sample_data), 32'd0);
        check_eq("t8_done", 32'(done), 32'd0);
        check_eq("t8_err", 32'(timeout_err), 32'd0);
        tick(2);
        @(posedge clk);
        #1 reset_reset_n = 1'b1;
        tick(4);
        clear_q();
        a0 = n_acks;
        r0 = n_rises;
        d0 = n_done;
        do_start(26'h0000900, 24'd0, 1'b1);
        tick(1);
        check_eq("t8_zero_busy", 32'(busy), 32'd1);
        check_eq("t8_zero_done_early", 32'(done), 32'd0);
        tick(1);
        check_eq("t8_zero_done", 32'(done), 32'd1);
        check_eq("t8_zero_idle", 32'(busy), 32'd0);
        tick(3);
        check_eq("t8_zero_no_read", 32'(n_rises - r0), 32'd0);
        check_eq("t8_zero_no_ack", 32'(n_acks - a0), 32'd0);
        check_eq("t8_zero_done_cnt", 32'(n_done - d0), 32'd1);

        check_eq("gap_violations", 32'(gap_viol), 32'd0);
        check_eq("hold_violations", 32'(hold_viol), 32'd0);
        check_eq("be_violations", 32'(be_viol), 32'd0);
        check_eq("write_violations", 32'(wr_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
